// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder between N_REQ requesters.
// One transaction in flight: IDLE (grant) -> EXEC (add) -> RESP (hold until accepted).
module adder_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     busy
);

    localparam int unsigned IDX_W = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_next;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              grant;
    logic              ack;

    // Round-robin scan starting at rr_ptr; idx is kept one bit wider so the wrap is a subtract.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(N_REQ)) begin
                idx = idx - IDX_W'(N_REQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                winner = idx[ID_W-1:0];
                found  = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the grant/accept strobes that steer the datapath.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is gated by reset_n so req_ready reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (grant && reset_n) begin
            req_ready = N_REQ'(1) << winner;
        end
    end

    assign rr_next = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            if (grant) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= winner;
            end
            if (state_q == EXEC) begin
                {carry_q, sum_q} <= {1'b0, a_q} + {1'b0, b_q};
            end
            if (ack) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized bench for adder_arbiter against a transaction-level round-robin/adder model.
module tb_adder_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    adder_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (ptr + k) % int'(N);
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < int'(N); i++) begin
            req_a[i*W +: W] = pick_operand();
            req_b[i*W +: W] = pick_operand();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_id"},    64'(rsp_id),    64'd0);
        check({tag, "_sum"},   64'(rsp_sum),   64'd0);
        check({tag, "_carry"}, 64'(rsp_carry), 64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
    endtask

    // One full transaction starting in IDLE; stall = RESP cycles with rsp_ready low.
    task automatic do_txn(input logic [N-1:0] v, input int stall, input bit rand_ops);
        int           w;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [63:0]  s;
        if (rand_ops) randomize_ops();
        req_valid = v;
        rsp_ready = 1'b0;
        w  = rr_pick(v, model_ptr);
        ea = req_a[w*W +: W];
        eb = req_b[w*W +: W];
        s  = 64'(ea) + 64'(eb);
        #1;
        check("grant_ready", 64'(req_ready), 64'd1 << w);
        check("grant_busy",  64'(busy),      64'd0);
        @(posedge clk); #1;
        req_valid = N'($urandom);
        rsp_ready = 1'($urandom);
        randomize_ops();
        #1;
        check("exec_ready", 64'(req_ready), 64'd0);
        check("exec_busy",  64'(busy),      64'd1);
        check("exec_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        for (int k = 0; k <= stall; k++) begin
            rsp_ready = (k == stall);
            req_valid = N'($urandom);
            randomize_ops();
            #1;
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_id",    64'(rsp_id),    64'(w));
            check("rsp_sum",   64'(rsp_sum),   64'(s[W-1:0]));
            check("rsp_carry", 64'(rsp_carry), 64'(s[W]));
            check("rsp_busy",  64'(busy),      64'd1);
            check("rsp_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        check("post_valid", 64'(rsp_valid), 64'd0);
        check("post_busy",  64'(busy),      64'd0);
        model_ptr = (w + 1) % int'(N);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        randomize_ops();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        req_valid = N'($urandom_range(1, 15));
        randomize_ops();
        #1;
        check_all_zero("reset_rand");

        @(posedge clk); #1;
        reset_n   = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_busy",  64'(busy),      64'd0);
            check("idle_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end

        // Round-robin with all requesters active: grants 0,1,2,3,0,1.
        for (int t = 0; t < 6; t++) do_txn(4'b1111, 0, 1'b1);

        // Single request from requester 2.
        randomize_ops();
        req_a[2*W +: W] = 32'h0000_0005;
        req_b[2*W +: W] = 32'h0000_0007;
        do_txn(4'b0100, 0, 1'b0);

        // Overflow cases.
        req_a[0 +: W] = 32'hFFFF_FFFF;
        req_b[0 +: W] = 32'h0000_0001;
        do_txn(4'b0001, 0, 1'b0);
        req_a[3*W +: W] = 32'h8000_0000;
        req_b[3*W +: W] = 32'h8000_0000;
        do_txn(4'b1000, 0, 1'b0);

        // Backpressure for 5 cycles in RESP.
        do_txn(4'b0010, 5, 1'b1);

        // Random traffic with random stalls and idle gaps.
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                req_valid = '0;
                #1;
                check("gap_ready", 64'(req_ready), 64'd0);
                check("gap_busy",  64'(busy),      64'd0);
                @(posedge clk); #1;
            end
            do_txn(N'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset during EXEC: move the pointer off zero first.
        do_txn(4'b0010, 0, 1'b1);
        req_valid = 4'b1111;
        #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy",  64'(busy),      64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n   = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("after_rst_valid", 64'(rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        model_ptr = 0;
        do_txn(4'b1111, 0, 1'b1);
        do_txn(4'b1111, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
